normalize_pipe: RTL and testbench

- Parametrised, two-stage pipelined normaliser and rounder for the Goldschmidt divider datapath.
- Takes a raw sign/exponent/wide-product triple from the iteration multiplier and finds the leading one.
- Shifts the product into place, adjusts the exponent, rounds to nearest-even and packs an IEEE-style word {S, E, F}.
- Saturates out-of-range exponents; valid/ready handshake on both sides, with full backpressure.

---
 rtl/normalize_pipe.sv | 131 +++++++++++++
 tb/tb_normalize_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_pipe.sv
// rtl/normalize_pipe.sv - two-stage leading-one normaliser, round-to-nearest-even and IEEE-style packer
// Stage S1 finds the leading one and left-justifies the product; S2 rounds, saturates and packs.
module normalize_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int PROD_W = 2*MAN_W+2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W+1:0]       in_exp,
    input  logic [PROD_W-1:0]      in_man,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_word,
    output logic                   out_ovf,
    output logic                   out_unf
);

    localparam int EW = EXP_W + 2;
    localparam int KW = $clog2(PROD_W);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic                   s1_valid_q;
    logic                   s1_sign_q;
    logic                   s1_zero_q;
    logic signed [EW-1:0]   s1_exp_q;
    logic [PROD_W-2:0]      s1_man_q;

    logic                   s2_valid_q;
    logic [EXP_W+MAN_W:0]   s2_word_q;
    logic                   s2_ovf_q;
    logic                   s2_unf_q;

    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_word  = s2_word_q;
    assign out_ovf   = s2_ovf_q;
    assign out_unf   = s2_unf_q;

    logic [KW-1:0]          lead_d;
    logic signed [EW-1:0]   s1_exp_d;
    logic [PROD_W-2:0]      s1_man_d;
    logic                   s1_zero_d;

    always_comb begin
        lead_d = '0;
        for (int i = 0; i < PROD_W; i++) begin
            if (in_man[i]) lead_d = KW'(i);
        end
    end

    // The hidden bit always lands at PROD_W-1, so only the bits below it are kept.
    assign s1_exp_d  = in_exp + EW'(lead_d) - EW'(PROD_W - 2);
    assign s1_man_d  = (PROD_W-1)'(in_man << (KW'(PROD_W - 1) - lead_d));
    assign s1_zero_d = ~|in_man;

    logic [MAN_W-1:0]       frac;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic                   carry;
    logic [MAN_W-1:0]       frac_r;
    logic signed [EW-1:0]   exp_r;
    logic [EXP_W+MAN_W:0]   s2_word_d;
    logic                   s2_ovf_d;
    logic                   s2_unf_d;

    assign frac     = s1_man_q[PROD_W-2 -: MAN_W];
    assign guard    = s1_man_q[PROD_W-2-MAN_W];
    assign sticky   = |s1_man_q[PROD_W-3-MAN_W:0];
    assign round_up = guard && (sticky || frac[0]);
    assign {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    assign exp_r    = s1_exp_q + EW'(carry);

    always_comb begin
        s2_word_d = {s1_sign_q, exp_r[EXP_W-1:0], frac_r};
        s2_ovf_d  = 1'b0;
        s2_unf_d  = 1'b0;
        if (s1_zero_q) begin
            s2_word_d = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
        end else if (exp_r >= EXP_MAX) begin
            s2_word_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            s2_ovf_d  = 1'b1;
        end else if (exp_r <= 0) begin
            s2_word_d = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
            s2_unf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_man_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_word_q  <= '0;
            s2_ovf_q   <= 1'b0;
            s2_unf_q   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q <= in_sign;
                    s1_zero_q <= s1_zero_d;
                    s1_exp_q  <= s1_exp_d;
                    s1_man_q  <= s1_man_d;
                end
            end
            // Output registers only load on a real item, so a stalled word holds.
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_word_q <= s2_word_d;
                    s2_ovf_q  <= s2_ovf_d;
                    s2_unf_q  <= s2_unf_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_normalize_pipe.sv
// tb/tb_normalize_pipe.sv - randomized and directed check of normalize_pipe against an arithmetic model
module tb_normalize_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_man = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic        out_ovf;
    logic        out_unf;

    int errors = 0;
    int checks = 0;

    logic [33:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [33:0] prev_out = '0;

    normalize_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Result as {ovf, unf, word}: value = man / 2^46 * 2^(exp-127), rounded to 24 significant bits.
    function automatic logic [33:0] model(input logic s, input logic [9:0] ex, input logic [47:0] man);
        int k;
        int e;
        int sh;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        if (man == 48'd0) return {2'b00, s, 31'd0};
        k = 0;
        for (int i = 0; i < 48; i++) if (man[i]) k = i;
        e = $signed(ex) + k - 46;
        if (k > 23) begin
            sh   = k - 23;
            q    = 64'(man) >> sh;
            rem  = 64'(man) & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end else begin
            q = 64'(man) << (23 - k);
        end
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], q[22:0]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_stable", 64'({out_ovf, out_unf, out_word}), 64'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    chk("stream_result", 64'({out_ovf, out_unf, out_word}), 64'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_sign, in_exp, in_man));
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_ovf, out_unf, out_word};
        end
    end

    task automatic directed(input string name, input logic s, input logic [9:0] ex, input logic [47:0] man,
                            input logic [31:0] word, input logic ovf, input logic unf);
        chk({name, "_model"}, 64'(model(s, ex, man)), 64'({ovf, unf, word}));
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = ex;
        in_man    = man;
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_not_early"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_word"}, 64'(out_word), 64'(word));
        chk({name, "_flags"}, 64'({out_ovf, out_unf}), 64'({ovf, unf}));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_item();
        logic [63:0] r;
        int ex;
        r  = {$urandom, $urandom};
        ex = int'($urandom_range(0, 500)) - 100;
        in_sign = r[63];
        in_exp  = ex[9:0];
        in_man  = r[47:0] >> $urandom_range(0, 47);
        if ($urandom_range(0, 15) == 0) in_man = '0;
        if ($urandom_range(0, 7) == 0) in_man[22:0] = 23'h400000;
    endtask

    initial begin
        logic [47:0] bp_man[4];
        int idx;
        int cyc;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_word", 64'(out_word), 64'd0);
        chk("reset_flags", 64'({out_ovf, out_unf}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        directed("n_2p25",   1'b0, 10'd127, 48'h900000000000, 32'h40100000, 1'b0, 1'b0);
        directed("n_neg1",   1'b1, 10'd127, 48'h400000000000, 32'hBF800000, 1'b0, 1'b0);
        directed("n_quart",  1'b0, 10'd127, 48'h100000000000, 32'h3E800000, 1'b0, 1'b0);
        directed("r_tie_ev", 1'b0, 10'd127, 48'h400000400000, 32'h3F800000, 1'b0, 1'b0);
        directed("r_tie_od", 1'b0, 10'd127, 48'h400000C00000, 32'h3F800002, 1'b0, 1'b0);
        directed("r_carry",  1'b0, 10'd127, 48'h7FFFFFFFFFFF, 32'h40000000, 1'b0, 1'b0);
        directed("x_ovf",    1'b0, 10'd254, 48'h900000000000, 32'h7F800000, 1'b1, 1'b0);
        directed("x_unf",    1'b0, 10'd1,   48'h100000000000, 32'h00000000, 1'b0, 1'b1);
        directed("x_zero",   1'b1, 10'd127, 48'h000000000000, 32'h80000000, 1'b0, 1'b0);

        bp_man[0] = 48'h900000000000;
        bp_man[1] = 48'h400000C00000;
        bp_man[2] = 48'h7FFFFFFFFFFF;
        bp_man[3] = 48'h123456789ABC;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 50) begin
            in_valid  = 1'b1;
            in_sign   = idx[0];
            in_exp    = 10'd120 + 10'(idx);
            in_man    = bp_man[idx];
            out_ready = (cyc >= 3);
            @(negedge clk);
            if (idx == 2 && !out_ready) chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
            if (in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd4);
        drain("bp");

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b0;
        in_exp    = 10'd127;
        in_man    = 48'h400000000000;
        @(posedge clk); #1;
        in_man    = 48'h900000000000;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_out_word", 64'(out_word), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid_no_stale", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_item();
            @(posedge clk); #1;
        end
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
